// File: rtl/barrido_primos_pkg.sv
// Shared types and golden primality reference for the prime sweep.
// Golden comparison logic is only instantiated with PRIME_CHECK_EN.
package barrido_primos_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ESPERA,
        FIN
    } estado_t;

    localparam logic [15:0] MASCARA_PRIMOS_4 = 16'h28AC;

    // Trial division by constant divisors; unrolls into a fixed comparator tree
    function automatic logic es_primo(input logic [15:0] n);
        logic p;
        p = (n >= 16'd2);
        for (int unsigned i = 2; i < 256; i++) begin
            if ((i * i) <= 32'(n) && (32'(n) % i) == 0) begin
                p = 1'b0;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/barrido_primos_temporizador.sv
// Dwell counter: counts while enabled, fin marks the last clock of a hold.
module temporizador_permanencia #(
    parameter int DWELL = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_fin
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_fin;

    assign w_fin = (r_cnt == CW'(DWELL - 1));
    assign o_fin = w_fin;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_fin ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/barrido_primos.sv
// Sweeps numero over all values, samples led_in per value, reports mask and count.
// Optional macro PRIME_CHECK_EN adds a golden primality comparator driving error.
module barrido_primos
    import barrido_primos_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DWELL = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                led_in,
    output logic [WIDTH-1:0]    numero,
    output logic                busy,
    output logic                done,
    output logic [2**WIDTH-1:0] mascara,
    output logic [WIDTH:0]      cuenta,
    output logic                error
);

    localparam logic [WIDTH-1:0] ULTIMO = WIDTH'(2**WIDTH - 1);

    estado_t             r_estado;
    logic [WIDTH-1:0]    r_numero;
    logic                r_busy;
    logic                r_done;
    logic [2**WIDTH-1:0] r_mascara;
    logic [WIDTH:0]      r_cuenta;
    logic                w_fin;
    logic                w_clr;
    logic                w_en;

    assign w_clr = (r_estado != ESPERA);
    assign w_en  = (r_estado == ESPERA);

    temporizador_permanencia #(
        .DWELL(DWELL)
    ) u_temp (
        .i_clk(clk),
        .i_rst(rst),
        .i_clr(w_clr),
        .i_en (w_en),
        .o_fin(w_fin)
    );

`ifdef PRIME_CHECK_EN
    logic r_error;
    logic w_golden;

    assign w_golden = es_primo(16'(r_numero));
    assign error    = r_error;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado  <= IDLE;
            r_numero  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mascara <= '0;
            r_cuenta  <= '0;
`ifdef PRIME_CHECK_EN
            r_error   <= 1'b0;
`endif
        end else begin
            unique case (r_estado)
                IDLE: begin
                    if (start) begin
                        r_numero  <= '0;
                        r_mascara <= '0;
                        r_cuenta  <= '0;
                        r_busy    <= 1'b1;
                        r_estado  <= ESPERA;
`ifdef PRIME_CHECK_EN
                        r_error   <= 1'b0;
`endif
                    end
                end
                ESPERA: begin
                    if (w_fin) begin
                        r_mascara[r_numero] <= led_in;
                        r_cuenta <= r_cuenta + (WIDTH + 1)'(led_in);
`ifdef PRIME_CHECK_EN
                        if (led_in != w_golden) begin
                            r_error <= 1'b1;
                        end
`endif
                        // Final value: stop here rather than wrapping numero
                        if (r_numero == ULTIMO) begin
                            r_done   <= 1'b1;
                            r_estado <= FIN;
                        end else begin
                            r_numero <= r_numero + 1'b1;
                        end
                    end
                end
                FIN: begin
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_estado <= IDLE;
                end
                default: begin
                    r_estado <= IDLE;
                end
            endcase
        end
    end

    assign numero  = r_numero;
    assign busy    = r_busy;
    assign done    = r_done;
    assign mascara = r_mascara;
    assign cuenta  = r_cuenta;

endmodule

// File: tb/tb_barrido_primos.sv
// Scoreboard bench for barrido_primos at DWELL=10 and DWELL=1.
// Expected error on the stub sweep follows PRIME_CHECK_EN.
module tb_barrido_primos;
    import barrido_primos_pkg::*;

    typedef struct {
        logic [15:0] m;
        logic [4:0]  c;
        logic        e;
        logic [3:0]  n;
        int          edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        stub = 1'b0;
    logic [15:0] tabla = MASCARA_PRIMOS_4;

    logic [3:0]  numero, numero1;
    logic        busy, busy1, done, done1, error, error1;
    logic [15:0] mascara, mascara1;
    logic [4:0]  cuenta, cuenta1;
    logic        led, led1;

    int checks = 0;
    int errors = 0;
    int ciclos = 0;
    int ndone = 0, ndone1 = 0;
    int npush = 0, npush1 = 0;
    exp_t q10[$];
    exp_t q1[$];

`ifdef PRIME_CHECK_EN
    localparam logic ERR_STUB = 1'b1;
`else
    localparam logic ERR_STUB = 1'b0;
`endif

    assign led  = stub ? 1'b1 : tabla[numero];
    assign led1 = tabla[numero1];

    always #5 clk = ~clk;
    always @(posedge clk) ciclos++;

    barrido_primos #(.WIDTH(4), .DWELL(10)) dut (
        .clk(clk), .rst(rst), .start(start), .led_in(led),
        .numero(numero), .busy(busy), .done(done),
        .mascara(mascara), .cuenta(cuenta), .error(error)
    );

    barrido_primos #(.WIDTH(4), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .led_in(led1),
        .numero(numero1), .busy(busy1), .done(done1),
        .mascara(mascara1), .cuenta(cuenta1), .error(error1)
    );

    task automatic comparar(input string nom, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nom, act, req);
        end
    endtask

    // Monitors: pop one expectation per done pulse
    always @(negedge clk) begin : mon10
        exp_t e;
        if (!rst && done) begin
            ndone++;
            if (q10.size() == 0) begin
                comparar("done10_unexpected", 1, 0);
            end else begin
                e = q10.pop_front();
                comparar("mascara10", int'(mascara), int'(e.m));
                comparar("cuenta10", int'(cuenta), int'(e.c));
                comparar("error10", int'(error), int'(e.e));
                comparar("numero10", int'(numero), int'(e.n));
                comparar("done_edge10", ciclos, e.edge_n);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && done1) begin
            ndone1++;
            if (q1.size() == 0) begin
                comparar("done1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                comparar("mascara1", int'(mascara1), int'(e.m));
                comparar("cuenta1", int'(cuenta1), int'(e.c));
                comparar("error1", int'(error1), int'(e.e));
                comparar("numero1", int'(numero1), int'(e.n));
                comparar("done_edge1", ciclos, e.edge_n);
            end
        end
    end

    task automatic empujar(input bit stub_v, input int acc);
        exp_t e;
        e.m = stub_v ? 16'hFFFF : 16'h28AC;
        e.c = stub_v ? 5'd16 : 5'd6;
        e.e = stub_v ? ERR_STUB : 1'b0;
        e.n = 4'd15;
        e.edge_n = acc + 160;
        q10.push_back(e);
        npush++;
    endtask

    task automatic arrancar(input bit stub_v, output int acc);
        @(negedge clk);
        stub = stub_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = ciclos;
        comparar("busy_after_start", int'(busy), 1);
        empujar(stub_v, acc);
    endtask

    task automatic esperar_done(input string nom, input int limite);
        int n = 0;
        while (!done && n < limite) begin
            @(negedge clk);
            n++;
        end
        if (!done) comparar(nom, 0, 1);
    endtask

    task automatic salir_fin;
        @(negedge clk);
        comparar("done_pulse_width", int'(done), 0);
        comparar("busy_after_fin", int'(busy), 0);
    endtask

    initial begin
        int acc;
        int n;
        exp_t e;

        repeat (3) @(negedge clk);
        comparar("rst_numero", int'(numero), 0);
        comparar("rst_busy", int'(busy), 0);
        comparar("rst_done", int'(done), 0);
        comparar("rst_mascara", int'(mascara), 0);
        comparar("rst_cuenta", int'(cuenta), 0);
        comparar("rst_error", int'(error), 0);
        rst = 1'b0;

        // 1: plain sweep
        arrancar(1'b0, acc);
        esperar_done("timeout_t1", 400);
        salir_fin();

        // 2: start held mid-sweep has no effect
        arrancar(1'b0, acc);
        repeat (30) @(negedge clk);
        start = 1'b1;
        repeat (50) @(negedge clk);
        comparar("busy_held", int'(busy), 1);
        start = 1'b0;
        esperar_done("timeout_t2", 400);
        salir_fin();

        // 2b: start held through FIN relaunches after one IDLE cycle
        arrancar(1'b0, acc);
        repeat (150) @(negedge clk);
        start = 1'b1;
        esperar_done("timeout_t2b", 400);
        @(negedge clk);
        comparar("idle_gap_busy", int'(busy), 0);
        @(negedge clk);
        comparar("relaunch_busy", int'(busy), 1);
        comparar("relaunch_numero", int'(numero), 0);
        start = 1'b0;
        empujar(1'b0, ciclos);
        esperar_done("timeout_t2c", 400);
        salir_fin();

        // 3: reset mid-sweep at numero 7
        arrancar(1'b0, acc);
        n = 0;
        while (numero != 4'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        comparar("reach_numero7", int'(numero), 7);
        rst = 1'b1;
        #1;
        comparar("arst_numero", int'(numero), 0);
        comparar("arst_busy", int'(busy), 0);
        comparar("arst_mascara", int'(mascara), 0);
        comparar("arst_cuenta", int'(cuenta), 0);
        comparar("arst_error", int'(error), 0);
        e = q10.pop_back();
        npush--;
        @(negedge clk);
        rst = 1'b0;
        arrancar(1'b0, acc);
        esperar_done("timeout_t3", 400);
        salir_fin();

        // 4: stub led always high
        arrancar(1'b1, acc);
        repeat (9) @(negedge clk);
        comparar("error_before_s0", int'(error), 0);
        @(negedge clk);
        comparar("error_after_s0", int'(error), int'(ERR_STUB));
        comparar("mascara_after_s0", int'(mascara), 1);
        esperar_done("timeout_t4", 400);
        salir_fin();
        stub = 1'b0;

        // 5: DWELL=1 instance
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        e.m = 16'h28AC;
        e.c = 5'd6;
        e.e = 1'b0;
        e.n = 4'd15;
        e.edge_n = ciclos + 16;
        q1.push_back(e);
        npush1++;
        repeat (3) @(negedge clk);
        comparar("dwell1_numero", int'(numero1), 3);
        n = 0;
        while (!done1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done1) comparar("timeout_t5", 0, 1);
        @(negedge clk);
        comparar("dwell1_done_width", int'(done1), 0);

        repeat (3) @(negedge clk);
        comparar("ndone10", ndone, npush);
        comparar("ndone1", ndone1, npush1);
        comparar("q10_empty", q10.size(), 0);
        comparar("q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
